risc_run_monitor: RTL and testbench

//  Synthesizable, parametrised run controller for the KGP RISC core: sequences the core's reset,

---
 rtl/risc_run_pkg.sv | 24 ++
 rtl/risc_run_monitor_trace_fifo.sv | 60 ++++++
 rtl/risc_run_monitor.sv | 124 ++++++++++++
 tb/tb_risc_run_monitor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_run_pkg.sv
// rtl/risc_run_pkg.sv - shared types and defaults for the RISC run monitor
// Contents: FSM state encoding, trace entry layout, default parameter values.
package risc_run_pkg;

    localparam int DEF_DATA_W       = 32;
    localparam int DEF_CNT_W        = 32;
    localparam int DEF_RESET_CYCLES = 4;
    localparam int DEF_MAX_CYCLES   = 10000;
    localparam int DEF_TRACE_DEPTH  = 16;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_RESET = 2'd1;
    localparam state_t S_RUN   = 2'd2;
    localparam state_t S_STOP  = 2'd3;

    // Trace entry at default widths; the FIFO stores {cycle, data} packed in this order.
    typedef struct packed {
        logic [DEF_CNT_W-1:0]  cycle;
        logic [DEF_DATA_W-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/risc_run_monitor_trace_fifo.sv
// rtl/risc_run_monitor_trace_fifo.sv - first-word fall-through trace FIFO
// Ports: clk, rst (async active-low), flush (drop contents), push/wdata, pop,
//        rdata (head, 0 when empty), empty, full, count (entries held).
module trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    // Empty head reads as zero so the outputs are defined after reset and flush.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/risc_run_monitor.sv
// rtl/risc_run_monitor.sv - run controller and output tracer for the KGP RISC core
// Ports: clk, rst (async active-low), start, cpu_out, cpu_halt in; cpu_rst_o, busy, done,
//        timeout, cycle_count out; trace_rd_en in; trace_data, trace_cycle, trace_empty,
//        trace_count, trace_overflow out.
module risc_run_monitor
    import risc_run_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int TRACE_DEPTH  = DEF_TRACE_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [DATA_W-1:0]            cpu_out,
    input  logic                         cpu_halt,
    output logic                         cpu_rst_o,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout,
    output logic [CNT_W-1:0]             cycle_count,
    input  logic                         trace_rd_en,
    output logic [DATA_W-1:0]            trace_data,
    output logic [CNT_W-1:0]             trace_cycle,
    output logic                         trace_empty,
    output logic [$clog2(TRACE_DEPTH):0] trace_count,
    output logic                         trace_overflow
);

    localparam int RCW = $clog2(RESET_CYCLES + 1);
    localparam int FW  = CNT_W + DATA_W;

    state_t            state;
    logic [RCW-1:0]    rst_cnt;
    logic              first_run;
    logic [DATA_W-1:0] last_val;
    logic              capture;
    logic              flush;
    logic              pop_eff;
    logic              fifo_full;
    logic [FW-1:0]     fifo_rdata;

    assign flush       = start && (state == S_IDLE || state == S_STOP);
    // The first RUN cycle always logs so the trace starts from a known value.
    assign capture     = (state == S_RUN) && (first_run || cpu_out != last_val);
    assign pop_eff     = trace_rd_en && !trace_empty;
    assign cpu_rst_o   = (state != S_RUN);
    assign busy        = (state == S_RESET) || (state == S_RUN);
    assign trace_cycle = fifo_rdata[FW-1:DATA_W];
    assign trace_data  = fifo_rdata[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            rst_cnt        <= '0;
            first_run      <= 1'b0;
            last_val       <= '0;
            cycle_count    <= '0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            trace_overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_STOP: begin
                    if (start) begin
                        state          <= S_RESET;
                        rst_cnt        <= '0;
                        cycle_count    <= '0;
                        done           <= 1'b0;
                        timeout        <= 1'b0;
                        trace_overflow <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == RCW'(RESET_CYCLES - 1)) begin
                        state     <= S_RUN;
                        first_run <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    first_run <= 1'b0;
                    // A dropped entry still advances the reference so later
                    // changes are judged against what the core actually drove.
                    if (capture) begin
                        last_val <= cpu_out;
                        if (fifo_full && !pop_eff) trace_overflow <= 1'b1;
                    end
                    // Halt has priority over the budget; the count freezes on exit.
                    if (cpu_halt) begin
                        state <= S_STOP;
                        done  <= 1'b1;
                    end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
                        state   <= S_STOP;
                        timeout <= 1'b1;
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    trace_fifo #(
        .WIDTH (FW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (capture),
        .pop   (trace_rd_en),
        .wdata ({cycle_count, cpu_out}),
        .rdata (fifo_rdata),
        .empty (trace_empty),
        .full  (fifo_full),
        .count (trace_count)
    );

endmodule

// File: tb/tb_risc_run_monitor.sv
// tb/tb_risc_run_monitor.sv - self-checking bench for risc_run_monitor
module tb_risc_run_monitor;

    localparam int DW    = 32;
    localparam int CW    = 32;
    localparam int RC    = 4;
    localparam int MAXC  = 100;
    localparam int DEPTH = 4;
    localparam int TCW   = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] cpu_out = '0;
    logic          cpu_halt = 1'b0;
    logic          trace_rd_en = 1'b0;
    logic          cpu_rst_o;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;
    logic [DW-1:0] trace_data;
    logic [CW-1:0] trace_cycle;
    logic          trace_empty;
    logic [TCW-1:0] trace_count;
    logic          trace_overflow;

    risc_run_monitor #(
        .DATA_W       (DW),
        .CNT_W        (CW),
        .RESET_CYCLES (RC),
        .MAX_CYCLES   (MAXC),
        .TRACE_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cpu_out        (cpu_out),
        .cpu_halt       (cpu_halt),
        .cpu_rst_o      (cpu_rst_o),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .cycle_count    (cycle_count),
        .trace_rd_en    (trace_rd_en),
        .trace_data     (trace_data),
        .trace_cycle    (trace_cycle),
        .trace_empty    (trace_empty),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   cyc;
        logic [DW-1:0] dat;
    } ent_t;

    ent_t          expq[$];
    logic [DW-1:0] vals [MAXC];
    bit            rds  [MAXC];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run: model the expected trace from the values the core shows,
    // then check status and drain the FIFO against the model.
    task automatic do_run(input int halt_at);
        int            k;
        int            last_i;
        bit            fin;
        bit            popped;
        bit            exp_ovf;
        logic [DW-1:0] lastv;
        expq.delete();
        exp_ovf = 1'b0;
        lastv   = '0;
        last_i  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
        chk("timeout_cleared", timeout, 0);
        chk("ovf_cleared", trace_overflow, 0);
        chk("empty_after_start", trace_empty, 1);
        k = 0;
        while (cpu_rst_o === 1'b1 && k < RC + 10) begin
            chk("busy_in_reset", busy, 1);
            k++;
            tick();
        end
        chk("reset_len", k, RC);
        fin = 1'b0;
        for (int i = 0; i < MAXC && !fin; i++) begin
            cpu_out     = vals[i];
            cpu_halt    = (i == halt_at);
            trace_rd_en = rds[i];
            start       = (i == 2);
            chk("run_count", cycle_count, i);
            chk("run_rst_low", cpu_rst_o, 0);
            chk("run_trace_count", trace_count, expq.size());
            popped = trace_rd_en && expq.size() > 0;
            if (popped) begin
                chk("run_pop_data", trace_data, expq[0].dat);
                chk("run_pop_cycle", trace_cycle, expq[0].cyc);
                void'(expq.pop_front());
            end
            if (i == 0 || vals[i] != lastv) begin
                lastv = vals[i];
                if (expq.size() < DEPTH) expq.push_back('{i, vals[i]});
                else exp_ovf = 1'b1;
            end
            fin    = (i == halt_at) || (i == MAXC - 1);
            last_i = i;
            tick();
        end
        cpu_halt    = 1'b0;
        trace_rd_en = 1'b0;
        start       = 1'b0;
        chk("end_count", cycle_count, last_i);
        chk("end_done", done, halt_at == last_i);
        chk("end_timeout", timeout, halt_at != last_i);
        chk("end_cpu_rst", cpu_rst_o, 1);
        chk("end_busy", busy, 0);
        chk("end_overflow", trace_overflow, exp_ovf);
        chk("end_trace_count", trace_count, expq.size());
        cpu_out = vals[0] + 32'd1;
        tick();
        chk("stop_count_held", cycle_count, last_i);
        chk("stop_trace_count_held", trace_count, expq.size());
        while (expq.size() > 0) begin
            chk("drain_not_empty", trace_empty, 0);
            chk("drain_data", trace_data, expq[0].dat);
            chk("drain_cycle", trace_cycle, expq[0].cyc);
            trace_rd_en = 1'b1;
            tick();
            trace_rd_en = 1'b0;
            void'(expq.pop_front());
        end
        chk("drained_empty", trace_empty, 1);
        chk("drained_count", trace_count, 0);
        trace_rd_en = 1'b1;
        tick();
        trace_rd_en = 1'b0;
        chk("pop_on_empty_count", trace_count, 0);
        chk("pop_on_empty_data", trace_data, 0);
        chk("pop_on_empty_cycle", trace_cycle, 0);
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            vals[i] = '0;
            rds[i]  = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int halt_r;
        // Reset state
        tick();
        tick();
        chk("rst_cpu_rst", cpu_rst_o, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_empty", trace_empty, 1);
        chk("rst_count", trace_count, 0);
        chk("rst_overflow", trace_overflow, 0);
        chk("rst_data", trace_data, 0);
        chk("rst_cycle", trace_cycle, 0);
        rst = 1'b1;
        tick();

        // Trace of 0,0,5,5,9 with halt on the fifth RUN cycle
        clear_stim();
        vals[0] = 32'd0; vals[1] = 32'd0; vals[2] = 32'd5; vals[3] = 32'd5; vals[4] = 32'd9;
        do_run(4);

        // Halt at RUN cycle 37 with a constant output
        clear_stim();
        for (int i = 0; i < MAXC; i++) vals[i] = 32'd7;
        do_run(37);

        // Halt coincident with the last budgeted cycle
        clear_stim();
        for (int i = 0; i < MAXC; i++) vals[i] = $urandom_range(0, 3);
        do_run(MAXC - 1);

        // Budget exhausted without halt
        clear_stim();
        for (int i = 0; i < MAXC; i++) vals[i] = (i / 10) * 3;
        do_run(-1);

        // Six distinct values, no pops: only the first four survive
        clear_stim();
        for (int i = 0; i < MAXC; i++) vals[i] = i + 1;
        do_run(5);

        // Push and pop together while full
        clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            vals[i] = i + 100;
            rds[i]  = (i >= 4);
        end
        do_run(7);

        // Asynchronous reset in the middle of a run
        clear_stim();
        for (int i = 0; i < MAXC; i++) vals[i] = i;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < RC + 10; i++) begin
            cpu_out = vals[i];
            tick();
        end
        chk("mid_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_cpu_rst", cpu_rst_o, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_empty", trace_empty, 1);
        chk("mid_rst_count", trace_count, 0);
        chk("mid_rst_cycle_count", cycle_count, 0);
        chk("mid_rst_done", done, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_after_release_busy", busy, 0);

        // Randomised runs
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < MAXC; i++) begin
                vals[i] = (r % 3 == 0) ? $urandom : $urandom_range(0, 3);
                rds[i]  = ($urandom_range(0, 3) == 0);
            end
            halt_r = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, MAXC - 1));
            do_run(halt_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
